// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state encoding and constants for the MIPS32 data-memory arbiter.
package mips_mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;
    localparam logic [31:0] DEAD_BEEF  = 32'hDEAD_BEEF;
    localparam int          DEF_ADDR_W = 32;
    localparam int          DEF_DATA_W = 32;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select, first requester after the pointer wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_any,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);
    logic [IW-1:0] w_j;
    always_comb begin
        o_any   = |i_req;
        o_grant = '0;
        o_idx   = '0;
        w_j     = '0;
        // farthest offset first so the nearest requester after the pointer overwrites it
        for (int k = N; k >= 1; k--) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_grant      = '0;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-core round-robin arbiter onto one req/ack data-memory port.
// Define ARB_TIMEOUT_EN to add the ack watchdog that releases the core with DEAD_BEEF and sets err.
module mem_arbiter_rr
    import mips_mem_pkg::*;
#(
    parameter int NUM_CORES      = 2,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        ch_req,
    input  logic [NUM_CORES-1:0]        ch_rd,
    input  logic [NUM_CORES*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CORES*DATA_W-1:0] ch_wdata,
    output logic [NUM_CORES-1:0]        ch_grant,
    output logic [DATA_W-1:0]           ch_rdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic                        err
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    arb_state_t           r_state;
    logic [IW-1:0]        r_ptr;
    logic [IW-1:0]        r_idx;
    logic [NUM_CORES-1:0] r_grant;
    logic                 w_any;
    logic [NUM_CORES-1:0] w_grant;
    logic [IW-1:0]        w_idx;
    logic                 w_to;

    rr_pick #(.N(NUM_CORES), .IW(IW)) u_pick (
        .i_req   (ch_req),
        .i_ptr   (r_ptr),
        .o_any   (w_any),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    assign w_to = (r_state == ST_ISSUE) && !mem_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else
            r_cnt <= (r_state == ST_ISSUE) ? CW'(r_cnt + 1'b1) : '0;
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= IW'(NUM_CORES - 1);
            r_idx     <= '0;
            r_grant   <= '0;
            ch_grant  <= '0;
            ch_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_state   <= ST_ISSUE;
                    r_idx     <= w_idx;
                    r_grant   <= w_grant;
                    mem_req   <= 1'b1;
                    mem_we    <= ~ch_rd[w_idx];
                    mem_addr  <= ch_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                    mem_wdata <= ch_wdata[int'(w_idx)*DATA_W +: DATA_W];
                    busy      <= 1'b1;
                end
                ST_ISSUE: if (mem_ack || w_to) begin
                    r_state   <= ST_DONE;
                    r_ptr     <= r_idx;
                    ch_grant  <= r_grant;
                    ch_rdata  <= w_to ? DATA_W'(DEAD_BEEF) : (mem_we ? '0 : mem_rdata);
                    err       <= err | w_to;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    ch_grant <= '0;
                    ch_rdata <= '0;
                    busy     <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: scoreboard bench for mem_arbiter_rr with 2-core and 4-core instances.
module tb_mem_arbiter_rr;
    typedef struct { logic [3:0] g; logic [31:0] d; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   req = '0, rd = '0, grant;
    logic [63:0]  addr = '0, wdata = '0;
    logic [31:0]  rdata, maddr, mwdata, mrdata = '0;
    logic         mreq, mwe, busy, err, ack = 1'b0;

    logic [3:0]   req4 = '0, grant4;
    logic [127:0] addr4 = {32'h130, 32'h120, 32'h110, 32'h100};
    logic [127:0] wdata4 = '0;
    logic [31:0]  rdata4, maddr4, mwdata4, mrdata4 = '0;
    logic         mreq4, mwe4, busy4, err4, ack4 = 1'b0;

    int   checks = 0, errors = 0, gseen = 0, g4seen = 0, g0 = 0;
    exp_t exp_q[$], exp4_q[$];
    exp_t e, e4;

    mem_arbiter_rr #(.NUM_CORES(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .ch_req(req), .ch_rd(rd), .ch_addr(addr), .ch_wdata(wdata),
        .ch_grant(grant), .ch_rdata(rdata), .mem_req(mreq), .mem_we(mwe), .mem_addr(maddr),
        .mem_wdata(mwdata), .mem_ack(ack), .mem_rdata(mrdata), .busy(busy), .err(err)
    );

    mem_arbiter_rr #(.NUM_CORES(4), .TIMEOUT_CYCLES(8)) dut4 (
        .clk(clk), .rst(rst), .ch_req(req4), .ch_rd(4'hF), .ch_addr(addr4), .ch_wdata(wdata4),
        .ch_grant(grant4), .ch_rdata(rdata4), .mem_req(mreq4), .mem_we(mwe4), .mem_addr(maddr4),
        .mem_wdata(mwdata4), .mem_ack(ack4), .mem_rdata(mrdata4), .busy(busy4), .err(err4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // zero-latency memory for the 4-core instance; read data echoes the address
    always @(negedge clk) begin
        ack4    = mreq4;
        mrdata4 = maddr4;
    end

    always @(negedge clk) if (rst && grant != 2'b00) begin
        gseen++;
        if (exp_q.size() == 0)
            chk("unexpected_grant", 32'(grant), 32'd0);
        else begin
            e = exp_q.pop_front();
            chk("grant", 32'(grant), 32'(e.g));
            chk("rdata", rdata, e.d);
        end
    end

    always @(negedge clk) if (rst && grant4 != 4'b0000) begin
        g4seen++;
        if (exp4_q.size() == 0)
            chk("unexpected_grant4", 32'(grant4), 32'd0);
        else begin
            e4 = exp4_q.pop_front();
            chk("grant4", 32'(grant4), 32'(e4.g));
            chk("rdata4", rdata4, e4.d);
        end
    end

    task automatic wait_issue(input string name, input int exp_n, input logic exp_we,
                              input logic [31:0] exp_a, input logic [31:0] exp_wd);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mreq && n < 20);
        chk({name, "_latency"}, 32'(n), 32'(exp_n));
        chk({name, "_we"}, 32'(mwe), 32'(exp_we));
        chk({name, "_addr"}, maddr, exp_a);
        if (exp_we) chk({name, "_wdata"}, mwdata, exp_wd);
        chk({name, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic ack_after(input int d, input logic [31:0] data,
                             input logic [31:0] exp_a, input logic [31:0] exp_wd);
        repeat (d) begin
            @(negedge clk);
            chk("hold_req", 32'(mreq), 32'd1);
            chk("hold_addr", maddr, exp_a);
            chk("hold_wdata", mwdata, exp_wd);
        end
        ack    = 1'b1;
        mrdata = data;
        @(posedge clk);
        #1 ack = 1'b0;
        mrdata = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mreq", 32'(mreq), 32'd0);
        chk("rst_mwe", 32'(mwe), 32'd0);
        chk("rst_maddr", maddr, 32'd0);
        chk("rst_mwdata", mwdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        ack = 1'b1; mrdata = 32'h77;
        repeat (3) @(negedge clk);
        chk("spur_mreq", 32'(mreq), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);
        ack = 1'b0; mrdata = '0;

        @(posedge clk);
        #1 req = 2'b01; rd = 2'b01; addr[31:0] = 32'h10;
        exp_q.push_back('{4'b0001, 32'h1234});
        wait_issue("read", 2, 1'b0, 32'h10, 32'h0);
        ack_after(2, 32'h1234, 32'h10, 32'h0);
        req = 2'b00;
        @(negedge clk);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_mreq", 32'(mreq), 32'd0);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        @(posedge clk);
        #1 req = 2'b10; rd = 2'b00; addr[63:32] = 32'h20; wdata[63:32] = 32'hCAFE;
        exp_q.push_back('{4'b0010, 32'h0});
        wait_issue("write", 2, 1'b1, 32'h20, 32'hCAFE);
        ack_after(3, 32'h5555, 32'h20, 32'hCAFE);
        req = 2'b00;
        repeat (2) @(negedge clk);

        @(posedge clk);
        #1 req = 2'b01; rd = 2'b01; addr[31:0] = 32'h30;
        exp_q.push_back('{4'b0001, 32'hBEEF});
        wait_issue("drop", 2, 1'b0, 32'h30, 32'h0);
        req = 2'b00;
        ack_after(1, 32'hBEEF, 32'h30, 32'h0);
        repeat (3) @(negedge clk);

        // pointer now sits on core 0, so core 1 wins before the reset
        @(posedge clk);
        #1 req = 2'b11; rd = 2'b11; addr = {32'h200, 32'h100};
        wait_issue("pre_rst", 2, 1'b0, 32'h200, 32'h0);
        #2 rst = 1'b0;
        #1 chk("rstmid_mreq", 32'(mreq), 32'd0);
        chk("rstmid_grant", 32'(grant), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{(k % 2) ? 4'b0010 : 4'b0001, 32'hA0 + 32'(k)});
            wait_issue("contend", (k == 0) ? 2 : 3, 1'b0, (k % 2) ? 32'h200 : 32'h100, 32'h0);
            ack_after(0, 32'hA0 + 32'(k), (k % 2) ? 32'h200 : 32'h100, 32'h0);
        end
        req = 2'b00;
        repeat (3) @(negedge clk);

        @(posedge clk);
        #1 req = 2'b01; rd = 2'b01; addr[31:0] = 32'h40;
`ifdef ARB_TIMEOUT_EN
        exp_q.push_back('{4'b0001, 32'hDEAD_BEEF});
`endif
        wait_issue("noack", 2, 1'b0, 32'h40, 32'h0);
        g0 = gseen;
        repeat (12) @(negedge clk);
`ifdef ARB_TIMEOUT_EN
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_grants", 32'(gseen - g0), 32'd1);
`else
        chk("noack_err", 32'(err), 32'd0);
        chk("noack_grants", 32'(gseen - g0), 32'd0);
        chk("noack_mreq", 32'(mreq), 32'd1);
`endif
        req = 2'b00;
        rst = 1'b0;
        #1 chk("post_rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int k = 0; k < 5; k++)
            exp4_q.push_back('{4'(4'b0001 << (k % 4)), 32'h100 + 32'(16 * (k % 4))});
        @(posedge clk);
        #1 req4 = 4'hF;
        begin
            int n = 0;
            while (g4seen < 5 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        req4 = 4'h0;
        chk("four_count", 32'(g4seen), 32'd5);

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("queue4_empty", 32'(exp4_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
